// File: rtl/rr_arbiter.sv
// Round-robin arbiter: N requesters, registered one-hot grant, rotating
// search pointer, optional cap on how long one holder may keep the grant
// while others wait (MAX_HOLD=0 means no cap).

// Per-requester cell: eligibility (requesting and not the current holder)
// and whether this requester sits at or above the search pointer.
module rr_arbiter_lane #(
  parameter int ID_W = 3,
  parameter int IDX  = 0
) (
  input  logic            req,
  input  logic            held,
  input  logic [ID_W-1:0] ptr,
  output logic            elig,
  output logic            upper
);
  assign elig  = req & ~held;
  assign upper = elig & (ID_W'(IDX) >= ptr);
endmodule

module rr_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N-1:0]                         req,
  output logic [N-1:0]                         grant,
  output logic                                 grant_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id
);
  localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  logic [ID_W-1:0]  ptr, ptr_n, win, gid_n;
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic [N-1:0]     elig, upper, grant_n;
  logic             any_elig, hreq, keep;

  // The holder is never eligible: when it re-arbitrates it has either
  // dropped its request or is being forced off by the hold limit.
  for (genvar i = 0; i < N; i++) begin : g_lane
    rr_arbiter_lane #(.ID_W(ID_W), .IDX(i)) u_lane (
      .req   (req[i]),
      .held  (grant[i]),
      .ptr   (ptr),
      .elig  (elig[i]),
      .upper (upper[i])
    );
  end

  // Winner search: lowest eligible bit at/above ptr, else wrap to lowest overall.
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) if (elig[i])  win = ID_W'(i);
    for (int i = N - 1; i >= 0; i--) if (upper[i]) win = ID_W'(i);
  end

  assign any_elig = |elig;
  assign hreq     = |(req & grant);
  assign keep     = (|grant) && hreq &&
                    ((MAX_HOLD == 0) || (hold_cnt < CNT_W'(MAX_HOLD)) || !any_elig);

  // Next-state: keep the holder, hand over to a new winner, or go idle.
  always_comb begin
    grant_n = grant;
    gid_n   = grant_id;
    ptr_n   = ptr;
    cnt_n   = hold_cnt;
    if (keep) begin
      if (MAX_HOLD == 0)                     cnt_n = CNT_W'(1);
      else if (hold_cnt < CNT_W'(MAX_HOLD))  cnt_n = hold_cnt + 1'b1;
    end else if (any_elig) begin
      for (int i = 0; i < N; i++) grant_n[i] = (ID_W'(i) == win);
      gid_n = win;
      ptr_n = (win == ID_W'(N - 1)) ? '0 : win + 1'b1;
      cnt_n = CNT_W'(1);
    end else begin
      grant_n = '0;
      gid_n   = '0;
      cnt_n   = '0;
    end
  end

  // State register with synchronous reset overriding any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= '0;
      grant_id <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      grant    <= grant_n;
      grant_id <= gid_n;
      ptr      <= ptr_n;
      hold_cnt <= cnt_n;
    end
  end

  assign grant_valid = |grant;

endmodule
